store_row: RTL and testbench
============================

STORE_ROW -- requirements
Module: store_row

Interface
REQ-001 Parameter IMAGE_WIDTH, default 128, input image width in pixels.
REQ-002 Parameter IMAGE_HEIGHT, default 128, input image height in pixels.
REQ-003 Parameter FILTER_SIZE, default 3, kernel edge; OUT_W = IMAGE_WIDTH-FILTER_SIZE+1, OUT_H = IMAGE_HEIGHT-FILTER_SIZE+1.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 store_en  input  1  request to write one convolved row to output BRAM.
REQ-007 row_count  input  16  output row index to write.
REQ-008 result_row_flat  input  OUT_W*8  convolved row; pixel k at bits [k*8 +: 8].
REQ-009 bram_en_a  output  1  BRAM port A enable.
REQ-010 bram_we_a  output  1  BRAM port A write enable.
REQ-011 bram_addr_a  output  clog2(OUT_W*OUT_H)  BRAM port A write address.
REQ-012 bram_data_a  output  8  BRAM port A write data.
REQ-013 stored  output  1  row write complete.
REQ-014 row_err  output  1  row_count out of range, no writes performed.

Function
REQ-015 The block SHALL implement states IDLE, WRITE, DONE; all outputs registered.
REQ-016 In IDLE with store_en=1, the block SHALL snapshot result_row_flat and row_count into internal registers, clear stored and row_err, and enter WRITE (or DONE, per REQ-020).
REQ-017 In WRITE the block SHALL present one pixel per cycle for OUT_W consecutive cycles: bram_en_a=1, bram_we_a=1, bram_addr_a=row*OUT_W+k, bram_data_a=pixel k, k=0..OUT_W-1 ascending.
REQ-018 The first write SHALL appear in the cycle following the edge that sampled store_en; there SHALL be no idle cycles between writes.
REQ-019 After pixel OUT_W-1, the next edge SHALL drive bram_en_a=0, bram_we_a=0, stored=1 and enter DONE.
REQ-020 If the snapshotted row_count >= OUT_H, the block SHALL perform no writes and enter DONE with stored=1 and row_err=1 on the next edge.
REQ-021 Address arithmetic SHALL be computed at ≥32-bit width, then truncated to bram_addr_a width.
REQ-022 Changes on result_row_flat, row_count or store_en during WRITE SHALL NOT affect the row in progress.
REQ-023 In DONE, stored (and row_err if set) SHALL hold while store_en=1; when store_en=0 the next edge SHALL clear stored and row_err and return to IDLE.
REQ-024 bram_en_a and bram_we_a SHALL be 0 in IDLE and DONE; bram_addr_a and bram_data_a hold their last values there.

Reset
REQ-025 rst=0 SHALL asynchronously force state IDLE and bram_en_a, bram_we_a, bram_addr_a, bram_data_a, stored, row_err, counter and snapshot to 0.
REQ-026 Reset during WRITE SHALL abort the row; already-written pixels remain in BRAM, no further writes occur.

Configuration
REQ-027 With macro STORE_CHECKSUM_EN defined, the block SHALL add output row_checksum (16 bits), reset 0, cleared on row start, accumulating each written byte modulo 2^16, stable and valid whenever stored=1 (0 when row_err=1).
REQ-028 Without STORE_CHECKSUM_EN, port row_checksum and its adder SHALL not exist; all other behaviour identical.

Verification
REQ-029 Default params, row_count=0, pixel k=k, store_en pulse held -> 126 writes addr 0..125 data 0..125 on consecutive cycles, stored=1 the cycle after addr 125.
REQ-030 row_count=125, all pixels 0xFF -> writes addr 15750..15875, data 0xFF; with STORE_CHECKSUM_EN row_checksum=0x7D82 (126*255).
REQ-031 row_count=126 -> no cycle with bram_we_a=1; stored=1, row_err=1 one cycle after sampling edge.
REQ-032 result_row_flat and row_count changed at write k=10 -> all 126 written bytes and addresses match the original snapshot.
REQ-033 rst=0 asserted during write k=50 -> bram_en_a=0, bram_we_a=0, stored=0 immediately; after release, no writes until a new store_en.
REQ-034 store_en held high after stored -> stored stays 1, no re-write; store_en low -> stored=0 next cycle, new store_en restarts at k=0.

Source files
------------

// File: rtl/store_row.sv
// store_row: streams one convolved row into the output BRAM, one byte per cycle.
// Optional feature macro STORE_CHECKSUM_EN adds a 16-bit running byte sum (row_checksum).
module store_row #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    localparam int OUT_W  = IMAGE_WIDTH - FILTER_SIZE + 1,
    localparam int OUT_H  = IMAGE_HEIGHT - FILTER_SIZE + 1,
    localparam int ADDR_W = $clog2(OUT_W * OUT_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store_en,
    input  logic [15:0]          row_count,
    input  logic [OUT_W*8-1:0]   result_row_flat,
    output logic                 bram_en_a,
    output logic                 bram_we_a,
    output logic [ADDR_W-1:0]    bram_addr_a,
    output logic [7:0]           bram_data_a,
    output logic                 stored,
    output logic                 row_err
`ifdef STORE_CHECKSUM_EN
    ,
    output logic [15:0]          row_checksum
`endif
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [15:0]          snap_row, snap_row_nxt;
    logic [OUT_W*8-1:0]   snap_pix, snap_pix_nxt;
    logic                 en_nxt, we_nxt, stored_nxt, err_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [7:0]           data_nxt;
`ifdef STORE_CHECKSUM_EN
    logic [15:0]          sum_nxt;
`endif

    // Pixel 0 is emitted straight from the live inputs on the sampling edge so the
    // first write lands in the very next cycle; later pixels come from the snapshot.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        snap_row_nxt = snap_row;
        snap_pix_nxt = snap_pix;
        en_nxt       = 1'b0;
        we_nxt       = 1'b0;
        addr_nxt     = bram_addr_a;
        data_nxt     = bram_data_a;
        stored_nxt   = stored;
        err_nxt      = row_err;
`ifdef STORE_CHECKSUM_EN
        sum_nxt      = row_checksum;
`endif
        case (state)
            IDLE: begin
                if (store_en) begin
                    snap_row_nxt = row_count;
                    snap_pix_nxt = result_row_flat;
                    stored_nxt   = 1'b0;
                    err_nxt      = 1'b0;
                    cnt_nxt      = '0;
                    if (32'(row_count) >= 32'(OUT_H)) begin
                        state_nxt  = DONE;
                        stored_nxt = 1'b1;
                        err_nxt    = 1'b1;
`ifdef STORE_CHECKSUM_EN
                        sum_nxt    = 16'd0;
`endif
                    end else begin
                        state_nxt = WRITE;
                        en_nxt    = 1'b1;
                        we_nxt    = 1'b1;
                        addr_nxt  = ADDR_W'(32'(row_count) * 32'(OUT_W));
                        data_nxt  = result_row_flat[7:0];
                        cnt_nxt   = CNT_W'(1);
`ifdef STORE_CHECKSUM_EN
                        sum_nxt   = {8'd0, result_row_flat[7:0]};
`endif
                    end
                end
            end
            WRITE: begin
                if (cnt == CNT_W'(OUT_W)) begin
                    state_nxt  = DONE;
                    stored_nxt = 1'b1;
                end else begin
                    en_nxt   = 1'b1;
                    we_nxt   = 1'b1;
                    addr_nxt = ADDR_W'(32'(snap_row) * 32'(OUT_W) + 32'(cnt));
                    data_nxt = snap_pix[32'(cnt)*8 +: 8];
                    cnt_nxt  = cnt + CNT_W'(1);
`ifdef STORE_CHECKSUM_EN
                    sum_nxt  = row_checksum + {8'd0, snap_pix[32'(cnt)*8 +: 8]};
`endif
                end
            end
            DONE: begin
                if (!store_en) begin
                    state_nxt  = IDLE;
                    stored_nxt = 1'b0;
                    err_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            snap_row    <= '0;
            snap_pix    <= '0;
            bram_en_a   <= 1'b0;
            bram_we_a   <= 1'b0;
            bram_addr_a <= '0;
            bram_data_a <= '0;
            stored      <= 1'b0;
            row_err     <= 1'b0;
`ifdef STORE_CHECKSUM_EN
            row_checksum <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            snap_row    <= snap_row_nxt;
            snap_pix    <= snap_pix_nxt;
            bram_en_a   <= en_nxt;
            bram_we_a   <= we_nxt;
            bram_addr_a <= addr_nxt;
            bram_data_a <= data_nxt;
            stored      <= stored_nxt;
            row_err     <= err_nxt;
`ifdef STORE_CHECKSUM_EN
            row_checksum <= sum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_store_row.sv
// tb_store_row: table-driven and randomized checks of store_row against a row-level model.
// Checksum comparisons are active when STORE_CHECKSUM_EN is defined.
module tb_store_row;
    localparam int W = 126;
    localparam int H = 126;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           store_en = 1'b0;
    logic [15:0]    row_count = '0;
    logic [W*8-1:0] result_row_flat = '0;
    logic           bram_en_a, bram_we_a, stored, row_err;
    logic [13:0]    bram_addr_a;
    logic [7:0]     bram_data_a;
`ifdef STORE_CHECKSUM_EN
    logic [15:0]    row_checksum;
`endif

    store_row dut (
        .clk             (clk),
        .rst             (rst),
        .store_en        (store_en),
        .row_count       (row_count),
        .result_row_flat (result_row_flat),
        .bram_en_a       (bram_en_a),
        .bram_we_a       (bram_we_a),
        .bram_addr_a     (bram_addr_a),
        .bram_data_a     (bram_data_a),
        .stored          (stored),
        .row_err         (row_err)
`ifdef STORE_CHECKSUM_EN
        ,
        .row_checksum    (row_checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cap_addr[$];
    int cap_data[$];
    logic [7:0] pix [W];

    typedef struct {
        int row;
        int kind;
        int fillv;
        int first_addr;
        int last_addr;
    } vec_t;
    vec_t vecs[6];

    // Every BRAM write seen on the port, recorded as the memory would see it.
    always @(negedge clk) begin
        if (bram_we_a) begin
            cap_addr.push_back(int'(bram_addr_a));
            cap_data.push_back(int'(bram_data_a));
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic fill(input int kind, input int fillv);
        for (int k = 0; k < W; k++) begin
            case (kind)
                0:       pix[k] = 8'(k);
                1:       pix[k] = 8'(fillv);
                default: pix[k] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic load_flat();
        for (int k = 0; k < W; k++) result_row_flat[k*8 +: 8] = pix[k];
    endtask

    // Expected content of one row: addresses row*W+k, data pix[k], k ascending.
    task automatic check_content(input string tag, input int row, input int n);
        int mism = 0;
        for (int k = 0; k < n && k < cap_addr.size(); k++) begin
            if (cap_addr[k] != row * W + k || cap_data[k] != int'(pix[k])) begin
                if (mism == 0)
                    $display("[TB] FAIL %s write %0d: got addr %0d data %0d, expected addr %0d data %0d",
                             tag, k, cap_addr[k], cap_data[k], row * W + k, pix[k]);
                mism++;
            end
        end
        check({tag, " mismatching writes"}, mism, 0);
    endtask

    task automatic run_row(input int row, input int disturb_at, input int first_addr,
                           input int last_addr, input string tag);
        int exp_err = (row >= H) ? 1 : 0;
        int lat = -1;
        int nw;
        int sum = 0;
        cap_addr.delete();
        cap_data.delete();
        @(negedge clk);
        row_count = 16'(row);
        load_flat();
        store_en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 300 && lat < 0; c++) begin
            @(negedge clk);
            #1;
            if (disturb_at >= 0 && cap_addr.size() == disturb_at + 1) begin
                for (int k = 0; k < W; k++) result_row_flat[k*8 +: 8] = 8'($urandom_range(0, 255));
                row_count = row_count + 16'd7;
            end
            if (stored) lat = c;
        end
        check({tag, " stored latency"}, lat, exp_err ? 1 : W + 1);
        check({tag, " write count"}, cap_addr.size(), exp_err ? 0 : W);
        check({tag, " row_err"}, int'(row_err), exp_err);
        if (!exp_err) begin
            check_content(tag, row, W);
            if (cap_addr.size() == W) begin
                check({tag, " first addr"}, cap_addr[0], first_addr);
                check({tag, " last addr"}, cap_addr[W-1], last_addr);
            end
        end
`ifdef STORE_CHECKSUM_EN
        if (!exp_err) for (int k = 0; k < W; k++) sum += int'(pix[k]);
        check({tag, " checksum"}, int'(row_checksum), sum % 65536);
`endif
        nw = cap_addr.size();
        repeat (5) @(negedge clk);
        check({tag, " stored held"}, int'(stored), 1);
        check({tag, " no rewrite"}, cap_addr.size(), nw);
        store_en = 1'b0;
        @(negedge clk);
        check({tag, " stored cleared"}, int'(stored), 0);
        check({tag, " row_err cleared"}, int'(row_err), 0);
    endtask

    initial begin
        vecs[0] = '{row: 0,     kind: 0, fillv: 0,   first_addr: 0,     last_addr: 125};
        vecs[1] = '{row: 125,   kind: 1, fillv: 255, first_addr: 15750, last_addr: 15875};
        vecs[2] = '{row: 126,   kind: 0, fillv: 0,   first_addr: -1,    last_addr: -1};
        vecs[3] = '{row: 1,     kind: 2, fillv: 0,   first_addr: 126,   last_addr: 251};
        vecs[4] = '{row: 65535, kind: 1, fillv: 255, first_addr: -1,    last_addr: -1};
        vecs[5] = '{row: 60,    kind: 1, fillv: 0,   first_addr: 7560,  last_addr: 7685};

        #12;
        check("reset bram_en_a", int'(bram_en_a), 0);
        check("reset bram_we_a", int'(bram_we_a), 0);
        check("reset stored", int'(stored), 0);
        check("reset row_err", int'(row_err), 0);
        check("reset bram_addr_a", int'(bram_addr_a), 0);
        check("reset bram_data_a", int'(bram_data_a), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].kind, vecs[i].fillv);
            run_row(vecs[i].row, -1, vecs[i].first_addr, vecs[i].last_addr, $sformatf("vec%0d", i));
        end

        fill(0, 0);
        run_row(3, 10, 378, 503, "disturb");

        // Abort a row with reset right after write k=50 has been presented.
        begin
            int ok = 0;
            fill(2, 0);
            cap_addr.delete();
            cap_data.delete();
            @(negedge clk);
            row_count = 16'd2;
            load_flat();
            store_en = 1'b1;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                #1;
                if (cap_addr.size() >= 51) ok = 1;
            end
            check("abort reached k=50", ok, 1);
            rst = 1'b0;
            #1;
            check("abort bram_en_a", int'(bram_en_a), 0);
            check("abort bram_we_a", int'(bram_we_a), 0);
            check("abort stored", int'(stored), 0);
            check_content("abort", 2, 51);
            store_en = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            repeat (150) @(negedge clk);
            check("abort no further writes", cap_addr.size(), 51);
        end

        fill(0, 0);
        run_row(4, -1, 504, 629, "restart");

        for (int i = 0; i < 8; i++) begin
            int r = $urandom_range(0, 131);
            fill(2, 0);
            run_row(r, -1, r * W, r * W + W - 1, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
